// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter
//
// Shares the 8-digit seven-segment display between three content sources:
// live status, a latched result and a transient error message. The error has
// the highest priority and a minimum on-screen hold time. A result that is
// preempted by an error is kept and shown again once the hold expires.
// The registered frame feeds the digit scanner.
//
// Optional feature: define SEG_ARB_BLINK_EN to blink the error digits in
// 250 ms on/off phases while an error is shown. With the macro undefined,
// the error enables stay steady and no phase counter is built.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   stat_code/stat_en   live status frame (digit 0 in [3:0]) and digit enables
//   res_req/res_ack     result request, held until the one-cycle ack
//   res_code/res_en     result frame captured on accept
//   res_clr             one-cycle pulse, discards the stored result
//   err_req/err_ack     error request, held until the one-cycle ack
//   err_code/err_en     error frame captured on accept
//   frame_code/frame_en registered frame to the scanner
//   frame_src           0 status, 1 result, 2 error
//   err_busy            high while the error is being held on screen

module seg_display_arbiter #(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned HOLD_MS = 2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] stat_code,
    input  logic [7:0]  stat_en,
    input  logic        res_req,
    input  logic [31:0] res_code,
    input  logic [7:0]  res_en,
    output logic        res_ack,
    input  logic        res_clr,
    input  logic        err_req,
    input  logic [31:0] err_code,
    input  logic [7:0]  err_en,
    output logic        err_ack,
    output logic [31:0] frame_code,
    output logic [7:0]  frame_en,
    output logic [1:0]  frame_src,
    output logic        err_busy
);

    localparam int unsigned HoldRaw = CLK_HZ / 1000 * HOLD_MS;
    localparam int unsigned HoldCyc = (HoldRaw < 1) ? 1 : HoldRaw;
    localparam int unsigned HoldW   = (HoldCyc > 1) ? $clog2(HoldCyc) : 1;
    localparam logic [HoldW-1:0] HoldLoad = HoldW'(HoldCyc - 1);

    // Encodings double as the frame_src value.
    typedef enum logic [1:0] {
        StStat = 2'd0,
        StRes  = 2'd1,
        StErr  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic             res_valid_q, res_valid_d;
    logic             res_arm_q, err_arm_q;
    logic             res_accept, err_accept;
    logic [31:0]      res_code_q, err_code_q;
    logic [7:0]       res_en_q, err_en_q;
    logic             res_ack_q, err_ack_q, err_busy_q;
    logic [31:0]      frame_code_q, frame_code_d;
    logic [7:0]       frame_en_q, frame_en_d;
    logic [1:0]       frame_src_q, frame_src_d;
    logic [7:0]       err_en_shown;

    assign res_accept = res_req & res_arm_q;
    assign err_accept = err_req & err_arm_q;

    // Result flag: a same-cycle accept beats the clear.
    always_comb begin
        res_valid_d = res_valid_q;
        if (res_accept) begin
            res_valid_d = 1'b1;
        end else if (res_clr) begin
            res_valid_d = 1'b0;
        end
    end

    // Next-state: an error accept preempts everything and restarts the hold.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        if (err_accept) begin
            state_d = StErr;
            hold_d  = HoldLoad;
        end else begin
            unique case (state_q)
                StStat: begin
                    if (res_accept) begin
                        state_d = StRes;
                    end
                end
                StRes: begin
                    if (res_clr && !res_accept) begin
                        state_d = StStat;
                    end
                end
                StErr: begin
                    if (hold_q == '0) begin
                        state_d = res_valid_d ? StRes : StStat;
                    end else begin
                        hold_d = hold_q - 1'b1;
                    end
                end
                default: state_d = StStat;
            endcase
        end
    end

`ifdef SEG_ARB_BLINK_EN
    localparam int unsigned PhaseRaw = CLK_HZ / 4;
    localparam int unsigned PhaseCyc = (PhaseRaw < 1) ? 1 : PhaseRaw;
    localparam int unsigned PhaseW   = (PhaseCyc > 1) ? $clog2(PhaseCyc) : 1;
    localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(PhaseCyc - 1);

    logic [PhaseW-1:0] phase_cnt_q, phase_cnt_d;
    logic              blink_on_q, blink_on_d;

    // Every error accept restarts the blink in its "on" phase.
    always_comb begin
        phase_cnt_d = phase_cnt_q;
        blink_on_d  = blink_on_q;
        if (err_accept) begin
            phase_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (state_q == StErr) begin
            if (phase_cnt_q == PhaseLast) begin
                phase_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                phase_cnt_d = phase_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            phase_cnt_q <= phase_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    assign err_en_shown = blink_on_q ? err_en_q : 8'h00;
`else
    assign err_en_shown = err_en_q;
`endif

    // Frame mux works off the current state, so content follows the state
    // change by one edge.
    always_comb begin
        frame_code_d = stat_code;
        frame_en_d   = stat_en;
        frame_src_d  = state_q;
        unique case (state_q)
            StStat: begin
                frame_code_d = stat_code;
                frame_en_d   = stat_en;
            end
            StRes: begin
                frame_code_d = res_code_q;
                frame_en_d   = res_en_q;
            end
            StErr: begin
                frame_code_d = err_code_q;
                frame_en_d   = err_en_shown;
            end
            default: begin
                frame_code_d = stat_code;
                frame_en_d   = stat_en;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StStat;
            hold_q       <= '0;
            res_valid_q  <= 1'b0;
            res_arm_q    <= 1'b1;
            err_arm_q    <= 1'b1;
            res_code_q   <= '0;
            res_en_q     <= '0;
            err_code_q   <= '0;
            err_en_q     <= '0;
            res_ack_q    <= 1'b0;
            err_ack_q    <= 1'b0;
            err_busy_q   <= 1'b0;
            frame_code_q <= '0;
            frame_en_q   <= '0;
            frame_src_q  <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            res_valid_q <= res_valid_d;
            // Re-arm only once the request has been seen low; a held request
            // therefore keeps the arm cleared after its single accept.
            res_arm_q   <= ~res_req;
            err_arm_q   <= ~err_req;
            if (res_accept) begin
                res_code_q <= res_code;
                res_en_q   <= res_en;
            end
            if (err_accept) begin
                err_code_q <= err_code;
                err_en_q   <= err_en;
            end
            res_ack_q    <= res_accept;
            err_ack_q    <= err_accept;
            err_busy_q   <= (state_d == StErr);
            frame_code_q <= frame_code_d;
            frame_en_q   <= frame_en_d;
            frame_src_q  <= frame_src_d;
        end
    end

    assign res_ack    = res_ack_q;
    assign err_ack    = err_ack_q;
    assign err_busy   = err_busy_q;
    assign frame_code = frame_code_q;
    assign frame_en   = frame_en_q;
    assign frame_src  = frame_src_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
module tb_seg_display_arbiter;

    localparam int unsigned ClkHz  = 4000;
    localparam int unsigned HoldMs = 5;
    localparam int unsigned Hold   = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] stat_code = '0;
    logic [7:0]  stat_en = '0;
    logic        res_req = 1'b0;
    logic [31:0] res_code = '0;
    logic [7:0]  res_en = '0;
    logic        res_ack;
    logic        res_clr = 1'b0;
    logic        err_req = 1'b0;
    logic [31:0] err_code = '0;
    logic [7:0]  err_en = '0;
    logic        err_ack;
    logic [31:0] frame_code;
    logic [7:0]  frame_en;
    logic [1:0]  frame_src;
    logic        err_busy;

    int total = 0;
    int bad = 0;

    seg_display_arbiter #(
        .CLK_HZ (ClkHz),
        .HOLD_MS(HoldMs)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stat_code (stat_code),
        .stat_en   (stat_en),
        .res_req   (res_req),
        .res_code  (res_code),
        .res_en    (res_en),
        .res_ack   (res_ack),
        .res_clr   (res_clr),
        .err_req   (err_req),
        .err_code  (err_code),
        .err_en    (err_en),
        .err_ack   (err_ack),
        .frame_code(frame_code),
        .frame_en  (frame_en),
        .frame_src (frame_src),
        .err_busy  (err_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts frames showing the error, optionally re-requesting the error
    // 10 cycles into the hold or pulsing res_clr mid-hold.
    task automatic err_window(input bit extend, input bit clr_mid, output int cnt);
        int content_bad;
        cnt = 0;
        content_bad = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (frame_src != 2'd2) break;
            cnt++;
            if (frame_en !== err_en || frame_code !== err_code) content_bad++;
            err_req = extend && (cnt == 9);
            res_clr = clr_mid && (cnt == 5);
        end
        err_req = 1'b0;
        res_clr = 1'b0;
        check("err_content_steady", content_bad, 0);
    endtask

    typedef struct {
        logic [31:0] sc;
        logic [7:0]  se;
        logic [31:0] ec;
        logic [7:0]  ee;
        logic [1:0]  es;
    } vec_t;

    typedef struct {
        logic [31:0] ec;
        logic [7:0]  ee;
        logic [1:0]  es;
    } exp_t;

    vec_t vecs[4];
    exp_t sb[$];

    initial begin
        int acks;
        int cnt;
        exp_t e;

        vecs[0] = '{32'h0000_0001, 8'h01, 32'h0000_0001, 8'h01, 2'd0};
        vecs[1] = '{32'h8765_4321, 8'hFF, 32'h8765_4321, 8'hFF, 2'd0};
        vecs[2] = '{32'h0000_0000, 8'h00, 32'h0000_0000, 8'h00, 2'd0};
        vecs[3] = '{32'hA5A5_5A5A, 8'hC3, 32'hA5A5_5A5A, 8'hC3, 2'd0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_frame_code", frame_code, 0);
        check("rst_frame_en", {24'h0, frame_en}, 0);
        check("rst_frame_src", {30'h0, frame_src}, 0);
        check("rst_res_ack", {31'h0, res_ack}, 0);
        check("rst_err_ack", {31'h0, err_ack}, 0);
        check("rst_err_busy", {31'h0, err_busy}, 0);
        rst_n = 1'b1;
        tick();

        // Status path through the scoreboard
        for (int i = 0; i < 4; i++) begin
            stat_code = vecs[i].sc;
            stat_en   = vecs[i].se;
            sb.push_back('{vecs[i].ec, vecs[i].ee, vecs[i].es});
            tick();
            e = sb.pop_front();
            check("stat_code", frame_code, e.ec);
            check("stat_en", {24'h0, frame_en}, {24'h0, e.ee});
            check("stat_src", {30'h0, frame_src}, {30'h0, e.es});
        end

        // Result held for 5 cycles: one ack, shown one edge after the accept
        res_code = 32'h0001_2345;
        res_en   = 8'h1F;
        res_req  = 1'b1;
        tick();
        check("res_ack_first", {31'h0, res_ack}, 1);
        check("res_src_not_yet", {30'h0, frame_src}, 0);
        acks = 1;
        tick();
        check("res_src", {30'h0, frame_src}, 1);
        check("res_code", frame_code, 32'h0001_2345);
        check("res_en", {24'h0, frame_en}, 32'h1F);
        acks += int'(res_ack);
        repeat (3) begin
            tick();
            acks += int'(res_ack);
        end
        res_req = 1'b0;
        tick();
        acks += int'(res_ack);
        check("res_ack_once", acks, 1);
        stat_code = 32'h0000_5555;
        stat_en   = 8'h0F;
        tick();
        check("res_ignores_stat", frame_code, 32'h0001_2345);

        // Error preempts the result for exactly the hold time
        err_code = 32'hEEEE_EEEE;
        err_en   = 8'hFF;
        err_req  = 1'b1;
        tick();
        check("err_ack", {31'h0, err_ack}, 1);
        check("err_busy", {31'h0, err_busy}, 1);
        err_req = 1'b0;
        err_window(1'b0, 1'b0, cnt);
        check("err_hold_len", cnt, Hold);
        check("err_back_src", {30'h0, frame_src}, 1);
        check("err_back_code", frame_code, 32'h0001_2345);
        check("err_busy_low", {31'h0, err_busy}, 0);

        // Second error 10 cycles in extends the total to 30
        err_req = 1'b1;
        tick();
        check("ext_ack", {31'h0, err_ack}, 1);
        err_req = 1'b0;
        err_window(1'b1, 1'b0, cnt);
        check("ext_hold_len", cnt, Hold + 10);
        check("ext_back_src", {30'h0, frame_src}, 1);

        // res_clr during the hold falls back to live status
        err_req = 1'b1;
        tick();
        err_req = 1'b0;
        err_window(1'b0, 1'b1, cnt);
        check("clr_hold_len", cnt, Hold);
        check("clr_src", {30'h0, frame_src}, 0);
        check("clr_code", frame_code, 32'h0000_5555);
        check("clr_en", {24'h0, frame_en}, 32'h0F);

        // Error and result together: both ack, error first, then the result
        res_code = 32'hABCD_0042;
        res_en   = 8'h3F;
        err_code = 32'h0000_0BAD;
        err_en   = 8'h0F;
        res_req  = 1'b1;
        err_req  = 1'b1;
        tick();
        check("both_res_ack", {31'h0, res_ack}, 1);
        check("both_err_ack", {31'h0, err_ack}, 1);
        res_req = 1'b0;
        err_req = 1'b0;
        err_window(1'b0, 1'b0, cnt);
        check("both_hold_len", cnt, Hold);
        check("both_src", {30'h0, frame_src}, 1);
        check("both_code", frame_code, 32'hABCD_0042);
        check("both_en", {24'h0, frame_en}, 32'h3F);

        // Reset mid-hold with the error request still held
        err_req = 1'b1;
        tick();
        repeat (7) tick();
        check("mid_busy", {31'h0, err_busy}, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_code", frame_code, 0);
        check("mid_rst_en", {24'h0, frame_en}, 0);
        check("mid_rst_src", {30'h0, frame_src}, 0);
        check("mid_rst_busy", {31'h0, err_busy}, 0);
        #2;
        rst_n = 1'b1;
        tick();
        check("rst_reaccept", {31'h0, err_ack}, 1);
        err_req = 1'b0;
        tick();
        check("rst_reaccept_src", {30'h0, frame_src}, 2);
        repeat (Hold + 5) tick();
        check("final_src", {30'h0, frame_src}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Shares the 8-digit seven-segment display between three content sources: live status (menu/mode), latched results (e.g. convolution cycle count), and transient error/notice messages. It sits upstream of the digit scanner and owns the frame that the scanner multiplexes. It enforces error > result > status priority, gives errors a minimum on-screen hold time, and keeps a preempted result so it can be restored afterwards.

## Interface
- CLK_HZ, 100_000_000, system clock frequency in Hz
- HOLD_MS, 2000, on-screen hold time of an error message in ms; HOLD_CYC = CLK_HZ/1000*HOLD_MS (≥1)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- stat_code  in  32  status frame, 8 digit codes × 4 bit, digit 0 in [3:0] (rightmost)
- stat_en  in  8  status digit enables, bit i = digit i
- res_req  in  1  result request, held high with data stable until res_ack
- res_code / res_en  in  32 / 8  result frame
- res_ack  out  1  one-cycle pulse, result captured
- res_clr  in  1  one-cycle pulse, discard stored result
- err_req  in  1  error request, same handshake as res_req
- err_code / err_en  in  32 / 8  error frame
- err_ack  out  1  one-cycle pulse, error captured
- frame_code  out  32  frame to scanner
- frame_en  out  8  digit enables to scanner
- frame_src  out  2  0 status, 1 result, 2 error
- err_busy  out  1  high while in S_ERR

## Operation
- States: S_STAT, S_RES, S_ERR. Reset → S_STAT.
- Handshake per requester: accept when req=1 and arm=1. On accept: capture code/en into the buffer, pulse ack, clear arm. arm is set again only after req is sampled low. A held-high req is therefore accepted exactly once.
- err accept, from any state: latch err buffer, load hold counter with HOLD_CYC-1, go to S_ERR. err accept while already in S_ERR: replace the buffer and restart the hold.
- res accept, from any state: latch res buffer, set res_valid.
  - From S_STAT: go to S_RES.
  - From S_ERR: stay in S_ERR; the new result is shown after the hold.
- res_clr: clears res_valid. S_RES → S_STAT. In S_ERR only the flag clears. res_clr and res accept in the same cycle: accept wins, res_valid=1.
- err and res accepted in the same cycle: both acks pulse and both buffers latch. Next state is S_ERR.
- S_ERR exit when the hold counter reaches 0: go to S_RES if res_valid, else S_STAT.
- Frame mux, registered: S_STAT passes stat_code/stat_en live; S_RES shows the res buffer; S_ERR shows the err buffer. frame_src follows the state.

## Timing
- Reset values: all outputs 0; state S_STAT; buffers 0; res_valid 0; arm 1.
- req sampled high at edge E:
  - ack is high for the cycle after E.
  - state and buffer update at E.
  - frame_* and frame_src update at E+1, so request-to-display latency is 2 edges.
- Status path: stat_* change visible on frame_* one edge later.
- S_ERR lasts exactly HOLD_CYC cycles after the last err accept. The frame leaves the error content one edge after the state exits.
- err_busy is registered alongside the state.
- Reset asserted mid-hold or mid-handshake: immediate return to reset values. A req still held high after reset is accepted again.

## Configuration
- SEG_ARB_BLINK_EN defined: in S_ERR, frame_en alternates between err_en and 8'h00 in 250 ms phases (CLK_HZ/4 cycles each). The phase starts "on" at every err accept.
- Not defined: frame_en = err_en steady throughout S_ERR; no phase counter is built.

## Test plan
Use CLK_HZ=4000, HOLD_MS=5, so HOLD_CYC=20.
- Reset, then stat_code=32'h0000_0001, stat_en=8'h01 → frame_code=32'h1, frame_en=8'h01, frame_src=0 one edge after input change.
- res_req held 5 cycles with res_code=32'h0001_2345, res_en=8'h1F → exactly one res_ack pulse; frame_src=1 and frame_code=32'h0001_2345 two edges after the first sample.
- In S_RES, err_req with err_code=32'hEEEE_EEEE → frame_src=2 for 20 cycles, then back to result 32'h0001_2345. Second err at cycle 10 extends the total to 30 cycles.
- res_clr during S_ERR → after the hold, frame_src=0 showing live status.
- err_req and res_req in the same cycle → both acks pulse together, error shown first, result shown after 20 cycles.
- rst_n low at cycle 7 of the hold → all outputs 0 immediately. With SEG_ARB_BLINK_EN and CLK_HZ=40, frame_en toggles every 10 cycles during the hold.
